// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Results beyond the DIGITS display range saturate to all nines and raise overflow.
module bin2bcd_seq #(
  parameter int W      = 11,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          bin_in,
  input  logic                  start,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int          BW    = 4 * DIGITS;
  localparam int          CW    = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned LIMIT = 10 ** DIGITS;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   bin_shift;
  logic [BW-1:0]  bcd_acc, bcd_adj, acc_nxt;
  logic [CW-1:0]  cnt;
  logic           ovf_pending;

  // Add-3 correction looks at each nibble before this cycle's shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    bcd_adj = bcd_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
    // Bit shifted out of the top nibble is dropped; that only happens on overflow.
    acc_nxt = BW'({bcd_adj, bin_shift[W-1]});
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD:  state_nxt = SHIFT;
      SHIFT: if (cnt == '0) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_shift   <= '0;
      bcd_acc     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      bcd_out     <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bin_shift   <= bin_in;
          bcd_acc     <= '0;
          ovf_pending <= 32'(bin_in) >= LIMIT;
        end
        LOAD: cnt <= CW'(W - 1);
        SHIFT: begin
          bin_shift <= {bin_shift[W-2:0], 1'b0};
          bcd_acc   <= acc_nxt;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            // Result is loaded on the edge into DONE so it is valid alongside the done pulse.
            bcd_out  <= ovf_pending ? {DIGITS{4'h9}} : acc_nxt;
            overflow <= ovf_pending;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: table of conversions plus multi-cycle corner sequences.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] bin_in;
  logic        start;
  logic        ready, busy, done, overflow;
  logic [11:0] bcd_out;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] prev_bcd = 12'h000;

  typedef struct {
    logic [10:0] bin;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  bin2bcd_seq #(.W(11), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .bin_in(bin_in), .start(start),
    .ready(ready), .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge with the block idle; returns at the falling edge after done.
  task automatic run_conv(input logic [10:0] b, input logic [11:0] exp_bcd, input logic exp_ovf);
    int cyc;
    check("ready_before_start", 32'(ready), 32'd1);
    bin_in = b;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 40) begin
      if (cyc == 6) check("bcd_hold_while_busy", 32'(bcd_out), 32'(prev_bcd));
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'd13);
    check("bcd_out", 32'(bcd_out), 32'(exp_bcd));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    prev_bcd = exp_bcd;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_after_done", 32'(ready), 32'd1);
  endtask

  initial begin
    int dcount, rlow, first_done, second_done;

    vecs[0]  = '{11'd0,    12'h000, 1'b0};
    vecs[1]  = '{11'd255,  12'h255, 1'b0};
    vecs[2]  = '{11'd999,  12'h999, 1'b0};
    vecs[3]  = '{11'd7,    12'h007, 1'b0};
    vecs[4]  = '{11'd100,  12'h100, 1'b0};
    vecs[5]  = '{11'd1000, 12'h999, 1'b1};
    vecs[6]  = '{11'd1998, 12'h999, 1'b1};
    vecs[7]  = '{11'd42,   12'h042, 1'b0};
    vecs[8]  = '{11'd1,    12'h001, 1'b0};
    vecs[9]  = '{11'd500,  12'h500, 1'b0};
    vecs[10] = '{11'd2047, 12'h999, 1'b1};
    vecs[11] = '{11'd19,   12'h019, 1'b0};

    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);

    // Start held high: accepts back to back, done every 14 cycles.
    bin_in = 11'd321;
    start  = 1'b1;
    dcount = 0; rlow = 0; first_done = 0; second_done = 0;
    for (int t = 1; t <= 41; t++) begin
      @(negedge clk);
      if (!ready) rlow++;
      if (done) begin
        dcount++;
        if (dcount == 1) first_done = t;
        if (dcount == 2) second_done = t;
      end
    end
    start = 1'b0;
    check("held_done_count", 32'(dcount), 32'd3);
    check("held_first_done", 32'(first_done), 32'd13);
    check("held_second_done", 32'(second_done), 32'd27);
    check("held_ready_low", 32'(rlow), 32'd39);
    check("held_bcd", 32'(bcd_out), 32'h321);
    @(negedge clk);
    prev_bcd = 12'h321;

    // Second start while busy is ignored, as is the bin_in change.
    bin_in = 11'd512;
    start  = 1'b1;
    dcount = 0; first_done = 0;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 5) begin bin_in = 11'd9; start = 1'b1; end
      if (done) begin
        dcount++;
        if (dcount == 1) begin
          first_done = t;
          check("ignore_bcd", 32'(bcd_out), 32'h512);
        end
      end
    end
    check("ignore_done_count", 32'(dcount), 32'd1);
    check("ignore_done_time", 32'(first_done), 32'd13);

    // Reset mid-conversion: outputs clear at once, no done, restart right after release.
    bin_in = 11'd777;
    start  = 1'b1;
    dcount = 0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dcount++;
    end
    reset = 1'b1;
    #1;
    check("midrst_bcd", 32'(bcd_out), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_no_done", 32'(dcount), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    prev_bcd = 12'h000;
    run_conv(11'd88, 12'h088, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
